if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the five-stage MIPS pipeline. It owns the program counter and drives the address of the combinational-read instruction memory. It captures the returned word into the IF/ID pipeline register. It applies hazard-unit stalls and flushes, and branch/jump redirects resolved in ID.

## Interface

- RESET_PC, 32'h0000_0000, PC value loaded on reset
- NOP_INSTR, 32'h0000_0000, bubble encoding (sll $0,$0,0) loaded into IF/ID on flush or reset

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- stall  in  1  hazard unit: hold PC and IF/ID contents
- flush  in  1  squash IF/ID to bubble next edge
- branch_taken  in  1  ID resolved a taken branch
- branch_target  in  32  byte address of branch destination
- jump  in  1  ID decoded J/JAL
- jump_index  in  26  instr[25:0] of the jump in ID
- imem_read_data  in  32  instruction word returned for imem_address (same cycle)
- imem_address  out  32  current PC, to instruction memory
- if_id_instr  out  32  registered instruction for ID
- if_id_pc_plus4  out  32  registered PC+4 of that instruction
- if_id_valid  out  1  1 = if_id_instr is a real fetched instruction
- misaligned_fault  out  1  sticky: a redirect target had nonzero bits [1:0]

## Operation

- PC register: imem_address = pc (direct register output, no combinational path from inputs).
- pc_plus4 = pc + 32'd4, modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000.
- Jump target = {if_id_pc_plus4[31:28], jump_index, 2'b00}.
- Next-PC priority, evaluated each edge:
  1. reset: pc <= RESET_PC.
  2. stall: pc holds. Redirect inputs are ignored; stall wins over jump/branch_taken.
  3. jump: pc <= jump target.
  4. branch_taken: pc <= {branch_target[31:2], 2'b00}.
  5. otherwise pc <= pc_plus4.
- IF/ID register priority:
  1. reset: instr <= NOP_INSTR, pc_plus4 <= 0, valid <= 0.
  2. flush, or an accepted redirect (jump or branch_taken with stall low): instr <= NOP_INSTR, valid <= 0, pc_plus4 <= 0. Flush wins over stall.
  3. stall: all IF/ID fields hold.
  4. otherwise instr <= imem_read_data, pc_plus4 <= pc_plus4, valid <= 1.
- The wrong-path instruction fetched during the redirect cycle is always squashed. There is no architectural delay slot.
- misaligned_fault sets on an accepted branch_taken with branch_target[1:0] != 0. It clears only on reset.
- Jump targets are aligned by construction and never set the fault.
- Only reset sets valid low in a cycle where flush is low and no redirect is accepted.

## Timing

- All state updates on rising clk. No asynchronous paths. Reset is sampled like any input.
- Reset values: imem_address = RESET_PC, if_id_instr = NOP_INSTR, if_id_pc_plus4 = 0, if_id_valid = 0, misaligned_fault = 0.
- Fetch latency: the word at address A appears on if_id_instr one edge after imem_address = A.
- Redirect penalty: one bubble. For a redirect accepted at edge N:
  - edge N: IF/ID loads the bubble and pc loads the target.
  - edge N+1: IF/ID loads the target instruction.
- Stall held for k cycles freezes pc and IF/ID for exactly k edges. Fetch resumes on the first edge with stall low.
- Reset asserted mid-operation (during stall or redirect) overrides everything on that edge.

## Test plan

Program image: word0 = 32'h00A60820, word1 = 32'h21420002, word2 = 32'h21830001, word3 = 32'h008A2020, word4 = 32'h02852822.

- Reset then free-run: imem_address steps 0, 4, 8, 12. Edge 1 after reset gives if_id_instr = 00A60820, pc_plus4 = 4, valid = 1. Edge 2 gives 21420002, pc_plus4 = 8.
- Stall asserted 2 cycles while pc = 8: imem_address stays 8 and if_id_instr stays 21420002 for 2 edges. The next edge loads 21830001.
- branch_taken with branch_target = 32'd16 while pc = 8:
  - next edge: pc = 16, IF/ID = NOP, valid = 0.
  - following edge: if_id_instr = 02852822, valid = 1.
- jump with jump_index = 26'd3 and if_id_pc_plus4 = 32'h0000_0008: pc becomes 32'h0000_000C, with a one-cycle bubble. Jump and branch_taken together: jump wins. Stall and jump together: pc holds and IF/ID holds.
- branch_target = 32'd6: pc becomes 4 and misaligned_fault = 1, staying 1 through later normal fetches until reset. Flush together with stall gives valid = 0 while pc holds.
- Reset asserted mid-stream, including during stall: on that edge pc = 0, IF/ID = NOP/0/0, fault = 0. The sequence then restarts from 00A60820.

Source files
------------

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage of the five-stage MIPS pipeline. Owns the program
// counter, addresses a combinational-read instruction memory, and captures the
// returned word into the IF/ID pipeline register. Applies hazard-unit stalls
// and flushes, plus branch/jump redirects resolved in ID.
//
// Ports:
//   clk              rising-edge clock
//   reset            synchronous, active-high
//   stall            hold PC and IF/ID contents
//   flush            squash IF/ID to a bubble on the next edge
//   branch_taken     ID resolved a taken branch
//   branch_target    byte address of the branch destination
//   jump             ID decoded J/JAL
//   jump_index       instr[25:0] of the jump sitting in ID
//   imem_read_data   instruction word for imem_address (same cycle)
//   imem_address     current PC (direct register output)
//   if_id_instr      registered instruction for ID
//   if_id_pc_plus4   registered PC+4 of that instruction
//   if_id_valid      1 = if_id_instr is a real fetched instruction
//   misaligned_fault sticky: an accepted branch target had nonzero bits [1:0]
// -----------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic [31:0] imem_read_data,
  output logic [31:0] imem_address,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        misaligned_fault
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] jump_target;
  logic [31:0] branch_aligned;
  logic        redirect;
  logic        branch_sel;

  // Wraps modulo 2^32 naturally.
  assign pc_plus4 = pc + 32'd4;

  // The jump sits in ID, so its region bits come from the IF/ID copy of PC+4.
  assign jump_target    = {if_id_pc_plus4[31:28], jump_index, 2'b00};
  assign branch_aligned = {branch_target[31:2], 2'b00};

  // A stall suppresses redirects entirely; ID will present them again.
  assign redirect   = !stall && (jump || branch_taken);
  // Branch only steers the PC when no jump competes with it.
  assign branch_sel = !stall && !jump && branch_taken;

  assign imem_address = pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (stall) begin
      pc <= pc;
    end else if (jump) begin
      pc <= jump_target;
    end else if (branch_taken) begin
      pc <= branch_aligned;
    end else begin
      pc <= pc_plus4;
    end
  end

  // The wrong-path word fetched in a redirect cycle is always discarded,
  // so an accepted redirect squashes IF/ID exactly like a flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      if_id_instr    <= NOP_INSTR;
      if_id_pc_plus4 <= 32'd0;
      if_id_valid    <= 1'b0;
    end else if (flush || redirect) begin
      if_id_instr    <= NOP_INSTR;
      if_id_pc_plus4 <= 32'd0;
      if_id_valid    <= 1'b0;
    end else if (stall) begin
      if_id_instr    <= if_id_instr;
      if_id_pc_plus4 <= if_id_pc_plus4;
      if_id_valid    <= if_id_valid;
    end else begin
      if_id_instr    <= imem_read_data;
      if_id_pc_plus4 <= pc_plus4;
      if_id_valid    <= 1'b1;
    end
  end

  // Sticky until reset; jump targets are aligned by construction.
  always_ff @(posedge clk) begin
    if (reset) begin
      misaligned_fault <= 1'b0;
    end else if (branch_sel && (branch_target[1:0] != 2'b00)) begin
      misaligned_fault <= 1'b1;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage
// Self-checking bench for if_stage: directed scenarios from the program image
// plus a randomized run compared against a behavioural model of the stage.
// -----------------------------------------------------------------------------
module tb_if_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [25:0] jump_index;
  logic [31:0] imem_read_data;
  logic [31:0] imem_address;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic        misaligned_fault;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [31:0] m_pc, m_instr, m_pp4;
  logic        m_valid, m_fault;

  if_stage dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .flush            (flush),
    .branch_taken     (branch_taken),
    .branch_target    (branch_target),
    .jump             (jump),
    .jump_index       (jump_index),
    .imem_read_data   (imem_read_data),
    .imem_address     (imem_address),
    .if_id_instr      (if_id_instr),
    .if_id_pc_plus4   (if_id_pc_plus4),
    .if_id_valid      (if_id_valid),
    .misaligned_fault (misaligned_fault)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instruction memory ----------------
  function automatic logic [31:0] imem_word(input logic [31:0] a);
    case (a)
      32'd0:   return 32'h00A6_0820;
      32'd4:   return 32'h2142_0002;
      32'd8:   return 32'h2183_0001;
      32'd12:  return 32'h008A_2020;
      32'd16:  return 32'h0285_2822;
      default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endcase
  endfunction

  assign imem_read_data = imem_word(imem_address);

  // ---------------- driver ----------------
  task automatic clear_inputs();
    reset = 1'b0; stall = 1'b0; flush = 1'b0;
    branch_taken = 1'b0; branch_target = 32'd0;
    jump = 1'b0; jump_index = 26'd0;
  endtask

  // Advance one edge; the model applies the stage's rules to the inputs
  // present at that edge, then outputs are sampled 1 time unit later.
  task automatic tick();
    logic [31:0] n_pc, n_instr, n_pp4;
    logic n_valid, n_fault;
    logic take_redirect;
    n_pc = m_pc; n_instr = m_instr; n_pp4 = m_pp4;
    n_valid = m_valid; n_fault = m_fault;
    if (reset) begin
      n_pc = 32'd0; n_instr = 32'd0; n_pp4 = 32'd0; n_valid = 1'b0; n_fault = 1'b0;
    end else begin
      take_redirect = !stall && (jump || branch_taken);
      if (stall)             n_pc = m_pc;
      else if (jump)         n_pc = {m_pp4[31:28], jump_index, 2'b00};
      else if (branch_taken) n_pc = branch_target & 32'hFFFF_FFFC;
      else                   n_pc = m_pc + 32'd4;
      if (flush || take_redirect) begin
        n_instr = 32'd0; n_pp4 = 32'd0; n_valid = 1'b0;
      end else if (!stall) begin
        n_instr = imem_word(m_pc); n_pp4 = m_pc + 32'd4; n_valid = 1'b1;
      end
      if (!stall && !jump && branch_taken && (branch_target % 4 != 0)) n_fault = 1'b1;
    end
    @(posedge clk);
    #1;
    m_pc = n_pc; m_instr = n_instr; m_pp4 = n_pp4; m_valid = n_valid; m_fault = n_fault;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++; if (imem_address !== 32'd0) begin errors++; $display("FAIL reset_pc got %h exp %h", imem_address, 32'd0); end
    checks++; if (if_id_instr !== 32'd0) begin errors++; $display("FAIL reset_instr got %h exp %h", if_id_instr, 32'd0); end
    checks++; if (if_id_pc_plus4 !== 32'd0) begin errors++; $display("FAIL reset_pp4 got %h exp %h", if_id_pc_plus4, 32'd0); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", if_id_valid); end
    checks++; if (misaligned_fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b exp 0", misaligned_fault); end
  endtask

  task automatic test_free_run();
    do_reset();
    tick();
    checks++; if (if_id_instr !== 32'h00A6_0820) begin errors++; $display("FAIL run_instr0 got %h exp %h", if_id_instr, 32'h00A6_0820); end
    checks++; if (if_id_pc_plus4 !== 32'd4) begin errors++; $display("FAIL run_pp4_0 got %h exp %h", if_id_pc_plus4, 32'd4); end
    checks++; if (if_id_valid !== 1'b1) begin errors++; $display("FAIL run_valid got %b exp 1", if_id_valid); end
    checks++; if (imem_address !== 32'd4) begin errors++; $display("FAIL run_pc1 got %h exp %h", imem_address, 32'd4); end
    tick();
    checks++; if (if_id_instr !== 32'h2142_0002) begin errors++; $display("FAIL run_instr1 got %h exp %h", if_id_instr, 32'h2142_0002); end
    checks++; if (if_id_pc_plus4 !== 32'd8) begin errors++; $display("FAIL run_pp4_1 got %h exp %h", if_id_pc_plus4, 32'd8); end
    checks++; if (imem_address !== 32'd8) begin errors++; $display("FAIL run_pc2 got %h exp %h", imem_address, 32'd8); end
    tick();
    checks++; if (imem_address !== 32'd12) begin errors++; $display("FAIL run_pc3 got %h exp %h", imem_address, 32'd12); end
  endtask

  task automatic test_stall();
    do_reset();
    tick(); tick();  // pc = 8, IF/ID holds word1
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (imem_address !== 32'd8) begin errors++; $display("FAIL stall_pc[%0d] got %h exp %h", i, imem_address, 32'd8); end
      checks++; if (if_id_instr !== 32'h2142_0002) begin errors++; $display("FAIL stall_instr[%0d] got %h exp %h", i, if_id_instr, 32'h2142_0002); end
    end
    stall = 1'b0;
    tick();
    checks++; if (if_id_instr !== 32'h2183_0001) begin errors++; $display("FAIL stall_resume got %h exp %h", if_id_instr, 32'h2183_0001); end
    checks++; if (imem_address !== 32'd12) begin errors++; $display("FAIL stall_resume_pc got %h exp %h", imem_address, 32'd12); end
  endtask

  task automatic test_branch();
    do_reset();
    tick(); tick();  // pc = 8
    branch_taken = 1'b1; branch_target = 32'd16;
    tick();
    branch_taken = 1'b0;
    checks++; if (imem_address !== 32'd16) begin errors++; $display("FAIL br_pc got %h exp %h", imem_address, 32'd16); end
    checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'd0) begin errors++; $display("FAIL br_bubble got v=%b i=%h exp v=0 i=0", if_id_valid, if_id_instr); end
    tick();
    checks++; if (if_id_instr !== 32'h0285_2822 || if_id_valid !== 1'b1) begin errors++; $display("FAIL br_target got v=%b i=%h exp v=1 i=02852822", if_id_valid, if_id_instr); end
    checks++; if (if_id_pc_plus4 !== 32'd20) begin errors++; $display("FAIL br_pp4 got %h exp %h", if_id_pc_plus4, 32'd20); end
  endtask

  task automatic test_jump();
    do_reset();
    tick(); tick();  // if_id_pc_plus4 = 8
    jump = 1'b1; jump_index = 26'd3;
    tick();
    jump = 1'b0;
    checks++; if (imem_address !== 32'h0000_000C) begin errors++; $display("FAIL j_pc got %h exp %h", imem_address, 32'h0000_000C); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL j_bubble got %b exp 0", if_id_valid); end
    tick();
    checks++; if (if_id_instr !== 32'h008A_2020 || if_id_valid !== 1'b1) begin errors++; $display("FAIL j_target got v=%b i=%h exp v=1 i=008a2020", if_id_valid, if_id_instr); end
    // jump beats branch
    do_reset();
    tick(); tick();
    jump = 1'b1; jump_index = 26'd3; branch_taken = 1'b1; branch_target = 32'd16;
    tick();
    clear_inputs();
    checks++; if (imem_address !== 32'h0000_000C) begin errors++; $display("FAIL j_vs_br got %h exp %h", imem_address, 32'h0000_000C); end
    // stall beats jump
    do_reset();
    tick(); tick();
    stall = 1'b1; jump = 1'b1; jump_index = 26'd3;
    tick();
    clear_inputs();
    checks++; if (imem_address !== 32'd8) begin errors++; $display("FAIL stall_j_pc got %h exp %h", imem_address, 32'd8); end
    checks++; if (if_id_instr !== 32'h2142_0002 || if_id_valid !== 1'b1) begin errors++; $display("FAIL stall_j_ifid got v=%b i=%h exp v=1 i=21420002", if_id_valid, if_id_instr); end
  endtask

  task automatic test_misaligned();
    do_reset();
    branch_taken = 1'b1; branch_target = 32'd6;
    tick();
    branch_taken = 1'b0;
    checks++; if (imem_address !== 32'd4) begin errors++; $display("FAIL mis_pc got %h exp %h", imem_address, 32'd4); end
    checks++; if (misaligned_fault !== 1'b1) begin errors++; $display("FAIL mis_fault got %b exp 1", misaligned_fault); end
    tick(); tick();
    checks++; if (misaligned_fault !== 1'b1) begin errors++; $display("FAIL mis_sticky got %b exp 1", misaligned_fault); end
    checks++; if (if_id_instr !== 32'h2183_0001) begin errors++; $display("FAIL mis_fetch got %h exp %h", if_id_instr, 32'h2183_0001); end
    // flush + stall: bubble while pc holds
    stall = 1'b1; flush = 1'b1;
    tick();
    clear_inputs();
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL flush_stall_valid got %b exp 0", if_id_valid); end
    checks++; if (imem_address !== 32'd12) begin errors++; $display("FAIL flush_stall_pc got %h exp %h", imem_address, 32'd12); end
    do_reset();
    checks++; if (misaligned_fault !== 1'b0) begin errors++; $display("FAIL mis_clear got %b exp 0", misaligned_fault); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick(); tick(); tick();
    stall = 1'b1; jump = 1'b1; jump_index = 26'd7;
    reset = 1'b1;
    tick();
    clear_inputs();
    checks++; if (imem_address !== 32'd0 || if_id_instr !== 32'd0 || if_id_pc_plus4 !== 32'd0 || if_id_valid !== 1'b0) begin
      errors++; $display("FAIL mid_reset got pc=%h i=%h p=%h v=%b exp all 0", imem_address, if_id_instr, if_id_pc_plus4, if_id_valid);
    end
    tick();
    checks++; if (if_id_instr !== 32'h00A6_0820) begin errors++; $display("FAIL mid_restart got %h exp %h", if_id_instr, 32'h00A6_0820); end
  endtask

  task automatic test_wrap();
    do_reset();
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    tick();
    clear_inputs();
    tick();
    checks++; if (imem_address !== 32'd0) begin errors++; $display("FAIL wrap_pc got %h exp %h", imem_address, 32'd0); end
    checks++; if (if_id_pc_plus4 !== 32'd0 || if_id_valid !== 1'b1) begin errors++; $display("FAIL wrap_pp4 got p=%h v=%b exp p=0 v=1", if_id_pc_plus4, if_id_valid); end
    // jump keeps the region bits of the instruction in ID
    branch_taken = 1'b1; branch_target = 32'hF000_0000;
    tick();
    clear_inputs();
    tick();
    jump = 1'b1; jump_index = 26'd5;
    tick();
    clear_inputs();
    checks++; if (imem_address !== 32'hF000_0014) begin errors++; $display("FAIL j_region got %h exp %h", imem_address, 32'hF000_0014); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      reset        = ($urandom_range(0, 49) == 0);
      stall        = ($urandom_range(0, 4) == 0);
      flush        = ($urandom_range(0, 9) == 0);
      jump         = ($urandom_range(0, 9) == 0);
      jump_index   = 26'($urandom_range(0, 15));
      branch_taken = ($urandom_range(0, 7) == 0);
      branch_target = 32'($urandom_range(0, 63));
      tick();
      checks++;
      if (imem_address !== m_pc || if_id_instr !== m_instr || if_id_pc_plus4 !== m_pp4 ||
          if_id_valid !== m_valid || misaligned_fault !== m_fault) begin
        errors++;
        $display("FAIL rand[%0d] got pc=%h i=%h p=%h v=%b f=%b exp pc=%h i=%h p=%h v=%b f=%b",
                 i, imem_address, if_id_instr, if_id_pc_plus4, if_id_valid, misaligned_fault,
                 m_pc, m_instr, m_pp4, m_valid, m_fault);
      end
    end
    clear_inputs();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    m_pc = 32'd0; m_instr = 32'd0; m_pp4 = 32'd0; m_valid = 1'b0; m_fault = 1'b0;
    clear_inputs();
    #2;
    test_reset();
    test_free_run();
    test_stall();
    test_branch();
    test_jump();
    test_misaligned();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
